channel_arbiter: RTL

- Sits between the 16 per-bank schedulers in the front end and the DRAM command bus.
- Each cycle it examines every bank's head request word, tracks per-bank row state and timing, and picks at most one DRAM command (ACT/PRE/RD/WR).
- When a column command is issued it returns a one-cycle grant to the bank scheduler, which pops that request.
- Shares the single command bus between banks: row-hit first, round-robin within priority class.

---
 rtl/channel_arbiter_pkg.sv | 37 +++
 rtl/channel_arbiter_rr_picker.sv | 39 +++
 rtl/channel_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/channel_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// channel_arbiter_pkg
//   Shared types for the DRAM channel arbiter: command encoding, per-bank row
//   state, priority class indices and a width helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package channel_arbiter_pkg;

   typedef enum logic [1:0] {
      CMD_ACT = 2'b00,
      CMD_PRE = 2'b01,
      CMD_RD  = 2'b10,
      CMD_WR  = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      BK_CLOSED  = 2'd0,
      BK_OPENING = 2'd1,
      BK_OPEN    = 2'd2,
      BK_CLOSING = 2'd3
   } bank_state_e;

   // Priority classes, index 0 is the highest.
   localparam int NUM_CLASSES  = 4;
   localparam int CLS_HIT_SAME = 0;   // row hit, same direction
   localparam int CLS_HIT_TURN = 1;   // row hit, opposite direction, turnaround done
   localparam int CLS_PRE      = 2;   // open bank, wrong row
   localparam int CLS_ACT      = 3;   // closed bank

   localparam logic DIR_READ = 1'b0;

   // Index width that stays legal for a single-entry vector.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/channel_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Round-robin first-set finder: scans i_req starting at i_start, wrapping
//   N-1 -> 0, and returns the first set position.
//   Ports:
//     i_req    in  N   request vector
//     i_start  in  IW  first position to examine
//     o_found  out 1   any request set
//     o_idx    out IW  winning position (0 when none)
// -----------------------------------------------------------------------------
module rr_picker
   import channel_arbiter_pkg::*;
#(
   parameter  int N  = 16,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_start,
   output logic          o_found,
   output logic [IW-1:0] o_idx
);

   logic [IW-1:0] w_pos;

   // Walk the offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_pos   = '0;
      for (int k = N-1; k >= 0; k--) begin
         w_pos = IW'((int'(i_start) + k) % N);
         if (i_req[w_pos]) begin
            o_found = 1'b1;
            o_idx   = w_pos;
         end
      end
   end

endmodule

// File: rtl/channel_arbiter.sv
// -----------------------------------------------------------------------------
// channel_arbiter
//   Shares one DRAM command bus between BANKS bank schedulers. Tracks per-bank
//   row state and timing, and issues at most one ACT/PRE/RD/WR per cycle:
//   row hits first, round-robin inside each priority class. Column commands
//   return a one-cycle pop strobe to the owning scheduler.
//   Ports:
//     clk          in  1               clock
//     rst          in  1               asynchronous active-high reset
//     req_i        in  BANKS x REQ     head request word of each bank
//     grant_o      out BANKS           one-hot pop strobe (RD/WR only)
//     cmd_valid_o  out 1               command issued this cycle
//     cmd_o        out 2               00 ACT, 01 PRE, 10 RD, 11 WR
//     cmd_bank_o   out log2(BANKS)     target bank
//     cmd_row_o    out ROW_BITS        ACT row, or the bank's open row
//     cmd_req_o    out REQ_SIZE        request word for RD/WR, else zero
// -----------------------------------------------------------------------------
module channel_arbiter
   import channel_arbiter_pkg::*;
#(
   parameter  int BANKS     = 16,
   parameter  int REQ_SIZE  = 32,
   parameter  int VALID_POS = 31,
   parameter  int TYPE_POS  = 30,
   parameter  int ROW_POS   = 14,
   parameter  int ROW_BITS  = 16,
   parameter  int T_RCD     = 4,
   parameter  int T_RP      = 4,
   parameter  int T_TURN    = 6,
   parameter  int TW        = 4,
   localparam int BW        = idx_w(BANKS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [BANKS-1:0][REQ_SIZE-1:0]   req_i,
   output logic [BANKS-1:0]                 grant_o,
   output logic                             cmd_valid_o,
   output logic [1:0]                       cmd_o,
   output logic [BW-1:0]                    cmd_bank_o,
   output logic [ROW_BITS-1:0]              cmd_row_o,
   output logic [REQ_SIZE-1:0]              cmd_req_o
);

   bank_state_e          r_state [BANKS];
   logic [TW-1:0]        r_timer [BANKS];
   logic [ROW_BITS-1:0]  r_row   [BANKS];
   logic                 r_dir;
   logic [TW-1:0]        r_turn;
   logic [BW-1:0]        r_rr_ptr;

   logic [NUM_CLASSES-1:0][BANKS-1:0] w_cls;
   logic [NUM_CLASSES-1:0]            w_found;
   logic [NUM_CLASSES-1:0][BW-1:0]    w_idx;

   logic                 w_issue;
   logic                 w_col;
   logic                 w_wr;
   cmd_e                 w_cmd;
   logic [BW-1:0]        w_bank;

   // ---------------------------------------------------------------------------
   // Candidate classification. A bank granted last cycle still shows the
   // popped head, so it is masked out for this cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_cls = '0;
      for (int b = 0; b < BANKS; b++) begin
         if (req_i[b][VALID_POS] && !grant_o[b]) begin
            if (r_state[b] == BK_OPEN) begin
               if (req_i[b][ROW_POS +: ROW_BITS] == r_row[b]) begin
                  if (req_i[b][TYPE_POS] == r_dir)
                     w_cls[CLS_HIT_SAME][b] = 1'b1;
                  else if (r_turn == '0)
                     w_cls[CLS_HIT_TURN][b] = 1'b1;
               end else begin
                  w_cls[CLS_PRE][b] = 1'b1;
               end
            end else if (r_state[b] == BK_CLOSED) begin
               w_cls[CLS_ACT][b] = 1'b1;
            end
         end
      end
   end

   for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_pick
      rr_picker #(.N(BANKS)) u_pick (
         .i_req   (w_cls[c]),
         .i_start (r_rr_ptr),
         .o_found (w_found[c]),
         .o_idx   (w_idx[c])
      );
   end

   // Highest populated class wins.
   always_comb begin
      w_bank = '0;
      w_cmd  = CMD_ACT;
      if      (w_found[CLS_HIT_SAME]) w_bank = w_idx[CLS_HIT_SAME];
      else if (w_found[CLS_HIT_TURN]) w_bank = w_idx[CLS_HIT_TURN];
      else if (w_found[CLS_PRE])      w_bank = w_idx[CLS_PRE];
      else if (w_found[CLS_ACT])      w_bank = w_idx[CLS_ACT];
      w_wr    = req_i[w_bank][TYPE_POS];
      w_issue = |w_found;
      w_col   = w_found[CLS_HIT_SAME] | w_found[CLS_HIT_TURN];
      if (w_col)                 w_cmd = w_wr ? CMD_WR : CMD_RD;
      else if (w_found[CLS_PRE]) w_cmd = CMD_PRE;
   end

   // ---------------------------------------------------------------------------
   // Per-bank row FSMs. The transient states are left on the edge where the
   // timer lands on 0, so ACT on cycle N allows a column command on N+T_RCD.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < BANKS; b++) begin
            r_state[b] <= BK_CLOSED;
            r_timer[b] <= '0;
            r_row[b]   <= '0;
         end
      end else begin
         for (int b = 0; b < BANKS; b++) begin
            if (r_timer[b] != '0)
               r_timer[b] <= r_timer[b] - TW'(1);
            case (r_state[b])
               BK_OPENING: if (r_timer[b] <= TW'(1)) r_state[b] <= BK_OPEN;
               BK_CLOSING: if (r_timer[b] <= TW'(1)) r_state[b] <= BK_CLOSED;
               default: ;
            endcase
            if (w_issue && w_bank == BW'(b)) begin
               if (w_cmd == CMD_ACT) begin
                  r_state[b] <= BK_OPENING;
                  r_timer[b] <= TW'(T_RCD - 1);
                  r_row[b]   <= req_i[b][ROW_POS +: ROW_BITS];
               end else if (w_cmd == CMD_PRE) begin
                  r_state[b] <= BK_CLOSING;
                  r_timer[b] <= TW'(T_RP - 1);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registered command bus, grant, direction/turnaround and rr pointer.
   // Command fields hold their last value on idle cycles.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_o     <= '0;
         cmd_valid_o <= 1'b0;
         cmd_o       <= 2'b00;
         cmd_bank_o  <= '0;
         cmd_row_o   <= '0;
         cmd_req_o   <= '0;
         r_dir       <= DIR_READ;
         r_turn      <= '0;
         r_rr_ptr    <= '0;
      end else begin
         grant_o     <= '0;
         cmd_valid_o <= w_issue;
         if (w_issue) begin
            cmd_o      <= w_cmd;
            cmd_bank_o <= w_bank;
            cmd_row_o  <= (w_cmd == CMD_ACT) ? req_i[w_bank][ROW_POS +: ROW_BITS]
                                             : r_row[w_bank];
            cmd_req_o  <= w_col ? req_i[w_bank] : '0;
         end
         if (w_col) begin
            grant_o[w_bank] <= 1'b1;
            r_dir           <= w_wr;
            r_rr_ptr        <= (w_bank == BW'(BANKS - 1)) ? '0 : w_bank + BW'(1);
         end
         // Turnaround window only restarts when the bus direction flips.
         if (w_col && (w_wr != r_dir))
            r_turn <= TW'(T_TURN - 1);
         else if (r_turn != '0)
            r_turn <= r_turn - TW'(1);
      end
   end

endmodule
